// File: rtl/axi_data_mem.sv
// AXI4 slave data memory: one outstanding INCR burst (read or write) at a time
// against a word-organised RAM. FIXED/WRAP are served as INCR and size is ignored.
module axi_data_mem #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int MEM_WORDS          = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic [2:0]                      s_axi_awsize,
  input  logic [1:0]                      s_axi_awburst,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  input  logic [2:0]                      s_axi_arsize,
  input  logic [1:0]                      s_axi_arburst,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rlast,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready
);
  localparam int BPW  = C_S_AXI_DATA_WIDTH / 8;
  localparam int LB   = $clog2(BPW);
  localparam int MAW  = $clog2(MEM_WORDS);
  // One spare bit so start word + 255 beats never wraps back into range.
  localparam int IDXW = C_S_AXI_ADDR_WIDTH - LB + 1;

  typedef enum logic [1:0] {IDLE, W_DATA, W_RESP, R_DATA} state_t;

  state_t                        state_q, state_d;
  logic [C_S_AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [IDXW-1:0]               idx_q, idx_d;
  logic [7:0]                    cnt_q, cnt_d;
  logic [7:0]                    len_q, len_d;
  logic                          err_q, err_d;
  logic                          bvalid_q, bvalid_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic                          rvalid_q, rvalid_d;
  logic                          rlast_q, rlast_d;
  logic [1:0]                    rresp_q, rresp_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic                          mem_we;
  logic                          beat_err;
  logic [IDXW-1:0]               aw_idx, ar_idx, rd_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
  logic                          unused_in;

  function automatic logic oob(input logic [IDXW-1:0] i);
    return i >= IDXW'(MEM_WORDS);
  endfunction

  assign aw_idx = {1'b0, s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:LB]};
  assign ar_idx = {1'b0, s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:LB]};
  // Word presented on the next rvalid: burst start from IDLE, else the following beat.
  assign rd_idx  = (state_q == IDLE) ? ar_idx : idx_q + IDXW'(1);
  assign rd_word = oob(rd_idx) ? '0 : mem[rd_idx[MAW-1:0]];

  assign unused_in = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst,
                       s_axi_awaddr[LB-1:0], s_axi_araddr[LB-1:0]};

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    err_d    = err_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    mem_we   = 1'b0;
    beat_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_axi_awvalid) begin
          id_d    = s_axi_awid;
          idx_d   = aw_idx;
          len_d   = s_axi_awlen;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = W_DATA;
        end else if (s_axi_arvalid) begin
          id_d     = s_axi_arid;
          idx_d    = ar_idx;
          len_d    = s_axi_arlen;
          cnt_d    = 8'd0;
          rdata_d  = rd_word;
          rresp_d  = oob(ar_idx) ? 2'b10 : 2'b00;
          rlast_d  = (s_axi_arlen == 8'd0);
          rvalid_d = 1'b1;
          state_d  = R_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid) begin
          mem_we   = !oob(idx_q);
          beat_err = oob(idx_q) || (s_axi_wlast != (cnt_q == len_q));
          err_d    = err_q || beat_err;
          idx_d    = idx_q + IDXW'(1);
          cnt_d    = cnt_q + 8'd1;
          // Burst length alone ends the burst; wlast only feeds the error flag.
          if (cnt_q == len_q) begin
            bvalid_d = 1'b1;
            bresp_d  = (err_q || beat_err) ? 2'b10 : 2'b00;
            state_d  = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            state_d  = IDLE;
          end else begin
            idx_d   = idx_q + IDXW'(1);
            cnt_d   = cnt_q + 8'd1;
            rdata_d = rd_word;
            rresp_d = oob(rd_idx) ? 2'b10 : 2'b00;
            rlast_d = ((cnt_q + 8'd1) == len_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      id_q     <= '0;
      idx_q    <= '0;
      cnt_q    <= 8'd0;
      len_q    <= 8'd0;
      err_q    <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      err_q    <= err_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BPW; b++) begin
        if (s_axi_wstrb[b]) mem[idx_q[MAW-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  assign s_axi_awready = (state_q == IDLE);
  assign s_axi_arready = (state_q == IDLE);
  assign s_axi_wready  = (state_q == W_DATA);
  assign s_axi_bid     = id_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_rid     = id_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rvalid  = rvalid_q;

endmodule

// File: tb/tb_axi_data_mem.sv
// Directed plus randomized bench for axi_data_mem against a word-array reference model.
module tb_axi_data_mem;
  localparam int MEM_WORDS = 1024;
  localparam int BPW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [0:0]  s_axi_awid = '0;
  logic [31:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = 3'd2;
  logic [1:0]  s_axi_awburst = 2'd1;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [0:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [0:0]  s_axi_arid = '0;
  logic [31:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = 3'd2;
  logic [1:0]  s_axi_arburst = 2'd1;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [0:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;

  axi_data_mem #(
    .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ID_WIDTH(1), .MEM_WORDS(MEM_WORDS)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int idx);
    if (idx < MEM_WORDS) return ref_mem[idx];
    return 32'h0;
  endfunction

  // Write burst of n beats from wbuf/sbuf; wlast is driven only on beat last_beat.
  task automatic axi_write(input int word, input int n, input int last_beat);
    int lat;
    int guard;
    bit err;
    logic [0:0] id;
    id = 1'($urandom);
    err = (last_beat != n - 1);
    for (int i = 0; i < n; i++) begin
      if (word + i < MEM_WORDS) begin
        for (int b = 0; b < 4; b++)
          if (sbuf[i][b]) ref_mem[word + i][8*b +: 8] = wbuf[i][8*b +: 8];
      end else err = 1'b1;
    end
    s_axi_awid    = id;
    s_axi_awaddr  = 32'(word * BPW) | 32'($urandom_range(0, 3));
    s_axi_awlen   = 8'(n - 1);
    s_axi_awburst = 2'($urandom_range(0, 2));
    s_axi_awvalid = 1'b1;
    guard = 0;
    while (!s_axi_awready && guard < 50) begin tick(); guard++; end
    check("aw_handshake", s_axi_awready, 1);
    tick();
    s_axi_awvalid = 1'b0;
    lat = 1;
    for (int i = 0; i < n; i++) begin
      s_axi_wdata  = wbuf[i];
      s_axi_wstrb  = sbuf[i];
      s_axi_wlast  = (i == last_beat);
      s_axi_wvalid = 1'b1;
      check("w_ready", s_axi_wready, 1);
      tick();
      lat++;
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    s_axi_bready = 1'b1;
    guard = 0;
    while (!s_axi_bvalid && guard < 20) begin tick(); guard++; lat++; end
    check("b_valid", s_axi_bvalid, 1);
    check("b_latency", lat, n + 1);
    check("b_id", s_axi_bid, id);
    check("b_resp", s_axi_bresp, err ? 2'b10 : 2'b00);
    tick();
    s_axi_bready = 1'b0;
    check("b_done_valid", s_axi_bvalid, 0);
    check("b_done_awready", s_axi_awready, 1);
  endtask

  // mode 0: rready held high, 1: pattern 1,0,0 repeating, 2: random
  task automatic axi_read(input int word, input int n, input int mode);
    int beat;
    int cyc;
    int guard;
    int bubbles;
    bit stalled;
    bit rr;
    logic [31:0] stall_data;
    logic stall_last;
    logic [0:0] id;
    id = 1'($urandom);
    s_axi_arid    = id;
    s_axi_araddr  = 32'(word * BPW) | 32'($urandom_range(0, 3));
    s_axi_arlen   = 8'(n - 1);
    s_axi_arburst = 2'($urandom_range(0, 2));
    s_axi_arvalid = 1'b1;
    guard = 0;
    while (!s_axi_arready && guard < 50) begin tick(); guard++; end
    check("ar_handshake", s_axi_arready, 1);
    tick();
    s_axi_arvalid = 1'b0;
    check("r_first_valid", s_axi_rvalid, 1);
    beat = 0; cyc = 0; bubbles = 0; stalled = 0;
    stall_data = '0; stall_last = 1'b0;
    while (beat < n && cyc < 4 * n + 20) begin
      case (mode)
        0: rr = 1'b1;
        1: rr = (cyc % 3 == 0);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      s_axi_rready = rr;
      if (stalled) begin
        check("r_stall_valid", s_axi_rvalid, 1);
        check("r_stall_data", s_axi_rdata, stall_data);
        check("r_stall_last", s_axi_rlast, stall_last);
      end
      if (s_axi_rvalid) begin
        if (rr) begin
          check("r_data", s_axi_rdata, exp_rd(word + beat));
          check("r_resp", s_axi_rresp, (word + beat < MEM_WORDS) ? 2'b00 : 2'b10);
          check("r_last", s_axi_rlast, beat == n - 1);
          check("r_id", s_axi_rid, id);
          beat++;
          stalled = 0;
        end else begin
          stalled = 1;
          stall_data = s_axi_rdata;
          stall_last = s_axi_rlast;
        end
      end else bubbles++;
      tick();
      cyc++;
    end
    s_axi_rready = 1'b0;
    check("r_beats", beat, n);
    if (mode == 0) check("r_bubbles", bubbles, 0);
    check("r_done_valid", s_axi_rvalid, 0);
    check("r_done_arready", s_axi_arready, 1);
  endtask

  initial begin
    int word;
    int n;
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", s_axi_awready, 1);
    check("rst_arready", s_axi_arready, 1);
    check("rst_wready", s_axi_wready, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_rdata", s_axi_rdata, 0);
    check("rst_rlast", s_axi_rlast, 0);
    check("rst_bresp", s_axi_bresp, 0);
    check("rst_rresp", s_axi_rresp, 0);
    check("rst_bid", s_axi_bid, 0);
    check("rst_rid", s_axi_rid, 0);
    reset = 1'b0;
    tick();

    // Fill the whole RAM with maximum-length bursts so every word is defined.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
      axi_write(k * 256, 256, 255);
    end

    // Single-beat write/read at 0x10
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    axi_write(4, 1, 0);
    axi_read(4, 1, 0);

    // 16-beat INCR at 0x100, data i*3, read back with rready held
    for (int i = 0; i < 16; i++) begin wbuf[i] = 32'(i * 3); sbuf[i] = 4'hF; end
    axi_write(64, 16, 15);
    axi_read(64, 16, 0);

    // Read backpressure
    axi_read(200, 4, 1);

    // Partial strobe plus simultaneous AW/AR
    wbuf[0] = 32'hAAAAAAAA; sbuf[0] = 4'hF;
    axi_write(300, 1, 0);
    s_axi_awid = 1'b1; s_axi_awaddr = 32'(300 * BPW); s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
    s_axi_arid = 1'b0; s_axi_araddr = 32'(300 * BPW); s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
    check("sim_awready", s_axi_awready, 1);
    tick();
    s_axi_awvalid = 1'b0;
    check("sim_ar_pending", s_axi_arready, 0);
    s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'h3; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    check("sim_wready", s_axi_wready, 1);
    tick();
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    ref_mem[300][15:0] = 16'h5678;
    check("sim_bvalid", s_axi_bvalid, 1);
    check("sim_bresp", s_axi_bresp, 0);
    check("sim_bid", s_axi_bid, 1);
    check("sim_no_rvalid", s_axi_rvalid, 0);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check("sim_arready", s_axi_arready, 1);
    tick();
    s_axi_arvalid = 1'b0;
    check("sim_rvalid", s_axi_rvalid, 1);
    check("sim_rdata", s_axi_rdata, 32'hAAAA5678);
    check("sim_rdata_model", s_axi_rdata, ref_mem[300]);
    check("sim_rlast", s_axi_rlast, 1);
    check("sim_rid", s_axi_rid, 0);
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    check("sim_done", s_axi_rvalid, 0);

    // Out-of-range tail and early wlast
    for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    axi_write(MEM_WORDS - 2, 4, 3);
    axi_read(MEM_WORDS - 2, 4, 0);
    for (int i = 0; i < 3; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    axi_write(500, 3, 1);
    axi_read(500, 3, 2);

    // Reset during beat 2 of an 8-beat read
    s_axi_arid = 1'b0; s_axi_araddr = 32'(64 * BPW); s_axi_arlen = 8'd7; s_axi_arvalid = 1'b1;
    check("rst_rd_arready", s_axi_arready, 1);
    tick();
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    check("rst_rd_beat0", s_axi_rdata, ref_mem[64]);
    tick();
    tick();
    check("rst_rd_beat2", s_axi_rdata, ref_mem[66]);
    reset = 1'b1;
    #1;
    check("mid_rst_rvalid", s_axi_rvalid, 0);
    check("mid_rst_rlast", s_axi_rlast, 0);
    check("mid_rst_bvalid", s_axi_bvalid, 0);
    check("mid_rst_wready", s_axi_wready, 0);
    check("mid_rst_awready", s_axi_awready, 1);
    check("mid_rst_arready", s_axi_arready, 1);
    s_axi_rready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    axi_read(64, 8, 0);

    // Randomized mix of bursts, some crossing the top of memory
    for (int t = 0; t < 30; t++) begin
      word = $urandom_range(0, MEM_WORDS + 4);
      n = $urandom_range(1, 16);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom); end
        axi_write(word, n, ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : n - 1);
      end else begin
        axi_read(word, n, $urandom_range(0, 2));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_data_mem.md
Name: axi_data_mem

Overview:
- AXI4 burst-capable slave data memory that sits directly downstream of the GPU memory controller's AXI master port.
- Serves INCR read and write bursts, one outstanding transaction at a time, from a word-organised on-chip RAM.
- Used as the data memory for simulation and for FPGA builds without external DRAM.

Parameters:
- C_S_AXI_ADDR_WIDTH, 32, byte address width.
- C_S_AXI_DATA_WIDTH, 32, data width; bytes per word BPW = C_S_AXI_DATA_WIDTH/8.
- C_S_AXI_ID_WIDTH, 1, transaction ID width.
- MEM_WORDS, 1024, RAM depth in words; must be a power of two.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- s_axi_awid / awaddr / awlen / awsize / awburst  in  ID / ADDR / 8 / 3 / 2  write address channel payload
- s_axi_awvalid  in  1; s_axi_awready  out  1
- s_axi_wdata  in  DATA; s_axi_wstrb  in  DATA/8; s_axi_wlast  in  1; s_axi_wvalid  in  1; s_axi_wready  out  1
- s_axi_bid  out  ID; s_axi_bresp  out  2; s_axi_bvalid  out  1; s_axi_bready  in  1
- s_axi_arid / araddr / arlen / arsize / arburst  in  ID / ADDR / 8 / 3 / 2  read address channel payload
- s_axi_arvalid  in  1; s_axi_arready  out  1
- s_axi_rid  out  ID; s_axi_rdata  out  DATA; s_axi_rresp  out  2; s_axi_rlast  out  1; s_axi_rvalid  out  1; s_axi_rready  in  1

Behaviour:
- Reset values: state IDLE; all valid and ready outputs 0 except awready and arready, which are 1 (derived from IDLE); rdata 0; bresp/rresp 0; IDs 0.
- Reset does not clear RAM contents. Reset mid-burst abandons the transaction and returns to IDLE.
- FSM states: IDLE, W_DATA, W_RESP, R_DATA.
- awready = arready = (state == IDLE), combinational from state.
- IDLE:
  - If awvalid is seen, latch ID, word index = awaddr / BPW, len = awlen, go to W_DATA.
  - Else if arvalid is seen, latch the read equivalents and go to R_DATA.
  - Write wins when both valid in the same cycle; AR stays pending.
- W_DATA:
  - wready = 1. Each beat with wvalid writes the bytes enabled by wstrb into mem[idx]; idx increments and beat count increments.
  - The final beat (count == len) moves to W_RESP.
  - Termination is by beat count only. If wlast is not asserted exactly on the final beat, record an error.
- W_RESP:
  - bvalid = 1, bid = latched ID.
  - bresp = 2'b10 (SLVERR) if a wlast mismatch or an out-of-range address was recorded, else 2'b00.
  - Hold bvalid until bready, then return to IDLE.
- R_DATA:
  - Registered output: first rvalid appears the cycle after the AR handshake, rdata = mem[idx].
  - rlast = (count == len).
  - On rready: advance idx and count, and present the next word the following cycle with no bubble (back-to-back beats when rready is held high).
  - Payload stays stable while rvalid=1 and rready=0.
  - After the last beat is accepted, return to IDLE.
- Address rules:
  - Beat index = start word + beat number.
  - Any beat with index ≥ MEM_WORDS is out of range: the write is dropped, the read returns 0 with rresp = SLVERR on that beat, and the error flag is set for bresp.
  - There is no wrap.
- Burst type and size: FIXED and WRAP bursts are treated as INCR. awsize/arsize are ignored; full-word beats are assumed. The max burst is 256 beats.
- awaddr/araddr low bits below BPW are ignored; the address is truncated to a word boundary.

Test Plan:
- Single-beat write: addr 0x10, data 0xDEADBEEF, wstrb 0xF → bresp 0, bvalid 2 cycles after the AW handshake. A read of addr 0x10 then returns 0xDEADBEEF with rlast=1.
- 16-beat INCR write at 0x100, data i*3 (awlen=15), then a 16-beat read at the same address with rready held 1 → 16 consecutive rvalid cycles, data 0,3,…,45, rlast only on beat 15.
- Read backpressure: 4-beat read with rready toggled 1,0,0,1,… → rdata and rlast stable while stalled; all 4 words delivered in order.
- wstrb 0x3 writing 0x12345678 over 0xAAAAAAAA → readback 0xAAAA5678. awvalid and arvalid asserted in the same cycle → write completes first, then the read is serviced.
- Boundary: 4-beat write starting at word MEM_WORDS-2 → first 2 words written, bresp SLVERR. wlast asserted early on beat 1 of a 3-beat burst → 3 beats still consumed, bresp SLVERR.
- Reset asserted during beat 2 of an 8-beat read → all valids drop immediately, awready/arready = 1. A subsequent read returns the previously written data intact.
